// File: rtl/ibniz_pkg.sv
// Shared constants for the IBNIZ scan sequencer: FSM encoding and 16.16 fixed-point defaults.
package ibniz_pkg;

    localparam int FIX_W    = 32;
    localparam int FIX_FRAC = 16;

    localparam logic [FIX_W-1:0] XY_STEP_DEFAULT = 32'h0000_0200;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/ibniz_tag_pipe.sv
// Fixed-depth delay line carrying pixel tags alongside the generator pipeline.
module ibniz_tag_pipe #(
    parameter int DEPTH = 26,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] tag_i,
    output logic [WIDTH-1:0] tag_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset, not just the head; a stale valid bit surviving
    // a mid-frame reset would produce a phantom pixel write afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (shift_en_i) begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ibniz_scan_seq.sv
// Raster scan sequencer: feeds T/X/Y to a fixed-latency generator and writes
// the returned values to a framebuffer with ready/valid backpressure.
module ibniz_scan_seq
    import ibniz_pkg::*;
#(
    parameter int               H_RES   = 256,
    parameter int               V_RES   = 192,
    parameter int               LAT     = 26,
    parameter logic [FIX_W-1:0] XY_STEP = XY_STEP_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            cont,
    input  logic [FIX_W-1:0]                t_step,
    output logic                            gen_ena,
    output logic [FIX_W-1:0]                T_out,
    output logic [FIX_W-1:0]                X_out,
    output logic [FIX_W-1:0]                Y_out,
    input  logic [FIX_W-1:0]                V_in,
    output logic                            pix_valid,
    input  logic                            pix_ready,
    output logic [$clog2(H_RES*V_RES)-1:0]  pix_addr,
    output logic [FIX_W-1:0]                pix_data,
    output logic                            busy,
    output logic                            frame_done
);

    localparam int NPIX = H_RES * V_RES;
    localparam int AW   = $clog2(NPIX);
    localparam int XW   = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int TW   = AW + 1;

    localparam logic [FIX_W-1:0] X_ORG = FIX_W'(0) - FIX_W'(H_RES / 2) * XY_STEP;
    localparam logic [FIX_W-1:0] Y_ORG = FIX_W'(0) - FIX_W'(V_RES / 2) * XY_STEP;
    localparam logic [AW-1:0]    LAST_ADDR = AW'(NPIX - 1);

    logic [1:0]       rst_sync_q;
    logic             run_ok;
    logic [1:0]       state_q, state_d;
    logic [FIX_W-1:0] x_q, x_d, y_q, y_d, t_q, t_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [XW-1:0]    xc_q, xc_d;
    logic             pix_valid_q, pix_valid_d;
    logic [AW-1:0]    pix_addr_q, pix_addr_d;
    logic [FIX_W-1:0] pix_data_q, pix_data_d;
    logic             adv, issue, last_issue, frame_start;
    logic [TW-1:0]    tag_in, tag_out;

    // Release of rst is synchronised so the FSM never leaves IDLE on a metastable edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign run_ok = rst_sync_q[1];

    assign adv         = (~pix_valid_q | pix_ready) & run_ok;
    assign issue       = (state_q == ST_RUN) & adv;
    assign last_issue  = issue & (addr_q == LAST_ADDR);
    assign frame_done  = pix_valid_q & pix_ready & (pix_addr_q == LAST_ADDR);
    assign frame_start = ((state_q == ST_IDLE) & start & run_ok)
                       | ((state_q == ST_DRAIN) & frame_done & cont);
    assign tag_in      = issue ? {1'b1, addr_q} : '0;

    ibniz_tag_pipe #(
        .DEPTH (LAT),
        .WIDTH (TW)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst),
        .shift_en_i (adv),
        .tag_i      (tag_in),
        .tag_o      (tag_out)
    );

    // NOTE: each output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        t_d         = t_q;
        addr_d      = addr_q;
        xc_d        = xc_q;
        pix_valid_d = pix_valid_q;
        pix_addr_d  = pix_addr_q;
        pix_data_d  = pix_data_q;

        case (state_q)
            ST_IDLE:  if (start && run_ok) state_d = ST_RUN;
            ST_RUN:   if (last_issue)      state_d = ST_DRAIN;
            ST_DRAIN: if (frame_done)      state_d = cont ? ST_RUN : ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase

        if (frame_start) begin
            x_d    = X_ORG;
            y_d    = Y_ORG;
            addr_d = '0;
            xc_d   = '0;
        end else if (issue) begin
            addr_d = addr_q + AW'(1);
            if (xc_q == XW'(H_RES - 1)) begin
                xc_d = '0;
                x_d  = X_ORG;
                y_d  = y_q + XY_STEP;
            end else begin
                xc_d = xc_q + XW'(1);
                x_d  = x_q + XY_STEP;
            end
        end

        if (frame_done) t_d = t_q + t_step;

        // Tag and V_in advance together, so the tag at the pipe tail always owns V_in.
        if (adv) begin
            pix_valid_d = tag_out[AW];
            if (tag_out[AW]) begin
                pix_data_d = V_in;
                pix_addr_d = tag_out[AW-1:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            t_q         <= '0;
            addr_q      <= '0;
            xc_q        <= '0;
            pix_valid_q <= 1'b0;
            pix_addr_q  <= '0;
            pix_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            t_q         <= t_d;
            addr_q      <= addr_d;
            xc_q        <= xc_d;
            pix_valid_q <= pix_valid_d;
            pix_addr_q  <= pix_addr_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign gen_ena   = adv;
    assign T_out     = t_q;
    assign X_out     = x_q;
    assign Y_out     = y_q;
    assign pix_valid = pix_valid_q;
    assign pix_addr  = pix_addr_q;
    assign pix_data  = pix_data_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_ibniz_scan_seq.sv
// Directed self-checking bench for ibniz_scan_seq on a 4x2 frame with a 3-cycle generator.
module tb_ibniz_scan_seq;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst, start, cont, pix_ready;
    logic [31:0] t_step;
    logic        gen_ena, pix_valid, busy, frame_done;
    logic [31:0] T_out, X_out, Y_out, V_in, pix_data;
    logic [2:0]  pix_addr;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] X_TAB [4] = '{32'hFFFF_FC00, 32'hFFFF_FE00, 32'h0000_0000, 32'h0000_0200};
    logic [31:0] Y_TAB [2] = '{32'hFFFF_FE00, 32'h0000_0000};

    logic [2:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          fd_count = 0;
    logic [2:0]  fd_addr  = '0;
    logic [31:0] gpipe [LAT];

    always #5 clk = ~clk;

    ibniz_scan_seq #(
        .H_RES (4),
        .V_RES (2),
        .LAT   (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cont       (cont),
        .t_step     (t_step),
        .gen_ena    (gen_ena),
        .T_out      (T_out),
        .X_out      (X_out),
        .Y_out      (Y_out),
        .V_in       (V_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    function automatic logic [31:0] gen_f(input logic [31:0] t, input logic [31:0] x, input logic [31:0] y);
        return t ^ (x + (y << 8));
    endfunction

    // Generator model: LAT enabled cycles from operands to V_in.
    always @(posedge clk) begin
        if (gen_ena) begin
            gpipe[0] <= gen_f(T_out, X_out, Y_out);
            for (int i = 1; i < LAT; i++) gpipe[i] <= gpipe[i-1];
        end
    end
    assign V_in = gpipe[LAT-1];

    always @(negedge clk) begin
        if (pix_valid && pix_ready) begin
            wr_addr.push_back(pix_addr);
            wr_data.push_back(pix_data);
        end
        if (frame_done) begin
            fd_count++;
            fd_addr = pix_addr;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        fd_count = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            tick();
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_frames(input string tag, input int n, input logic [31:0] t0, input logic [31:0] t1);
        check({tag, "_count"}, wr_addr.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < wr_addr.size()) begin
                int a;
                a = i % 8;
                check({tag, "_addr"}, {29'd0, wr_addr[i]}, a);
                check({tag, "_data"}, wr_data[i], gen_f((i < 8) ? t0 : t1, X_TAB[a % 4], Y_TAB[a / 4]));
            end
        end
    endtask

    initial begin
        logic [2:0]  snap_addr;
        logic [31:0] snap_data;
        int          gaps;
        logic        found;

        // Reset state
        rst = 1'b0; start = 1'b0; cont = 1'b0; t_step = '0; pix_ready = 1'b1;
        repeat (3) tick();
        check("rst_gen_ena", {31'd0, gen_ena}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_pix_valid", {31'd0, pix_valid}, 0);
        check("rst_xy", X_out | Y_out | T_out, 0);
        check("rst_addr_data", {29'd0, pix_addr} | pix_data, 0);
        rst = 1'b1;
        repeat (3) tick();
        check("post_sync_gen_ena", {31'd0, gen_ena}, 1);

        // Single frame: X/Y trace and issue-to-valid latency
        clear_log();
        pulse_start();
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                check("trace_x", X_out, X_TAB[k % 4]);
                check("trace_y", Y_out, Y_TAB[k / 4]);
                check("trace_busy", {31'd0, busy}, 1);
            end
            if (k == 3) check("lat_not_yet", {31'd0, pix_valid}, 0);
            if (k == 4) begin
                check("lat_valid", {31'd0, pix_valid}, 1);
                check("lat_addr", {29'd0, pix_addr}, 0);
            end
            tick();
        end
        wait_idle("f1_idle");
        check_frames("f1", 8, 32'h0, 32'h0);
        check("f1_done_count", fd_count, 1);
        check("f1_done_addr", {29'd0, fd_addr}, 7);

        // Backpressure: pix_ready low for 5 cycles mid-frame
        clear_log();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (pix_valid && pix_addr == 3'd2) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("stall_reach", {31'd0, found}, 1);
        pix_ready = 1'b0;
        #1;
        snap_addr = pix_addr;
        snap_data = pix_data;
        for (int j = 0; j < 5; j++) begin
            check("stall_gen_ena", {31'd0, gen_ena}, 0);
            check("stall_addr", {29'd0, pix_addr}, {29'd0, snap_addr});
            check("stall_data", pix_data, snap_data);
            tick();
        end
        pix_ready = 1'b1;
        wait_idle("stall_idle");
        check_frames("stall", 8, 32'h0, 32'h0);
        check("stall_done_count", fd_count, 1);

        // Continuous mode with T stepping
        clear_log();
        cont = 1'b1;
        t_step = 32'h0001_0000;
        pulse_start();
        check("cont_t0", T_out, 32'h0);
        for (int i = 0; i < 60; i++) begin
            if (fd_count >= 1) break;
            tick();
        end
        check("cont_first_done", fd_count, 1);
        check("cont_t1", T_out, 32'h0001_0000);
        check("cont_still_busy", {31'd0, busy}, 1);
        cont = 1'b0;
        gaps = 0;
        for (int i = 0; i < 60; i++) begin
            if (fd_count >= 2) break;
            if (!busy) gaps++;
            tick();
        end
        check("cont_gaps", gaps, 0);
        wait_idle("cont_idle");
        check_frames("cont", 16, 32'h0, 32'h0001_0000);
        check("cont_done_count", fd_count, 2);
        check("cont_t2", T_out, 32'h0002_0000);

        // Reset mid-frame at address 3
        t_step = '0;
        clear_log();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (pix_valid && pix_addr == 3'd3) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("mid_rst_reach", {31'd0, found}, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_outs", {28'd0, gen_ena, busy, pix_valid, frame_done}, 0);
        check("mid_rst_xyt", X_out | Y_out | T_out, 0);
        check("mid_rst_addr_data", {29'd0, pix_addr} | pix_data, 0);
        clear_log();
        tick();
        rst = 1'b1;
        repeat (8) tick();
        check("post_rst_no_write", wr_addr.size(), 0);
        check("post_rst_busy", {31'd0, busy}, 0);
        pulse_start();
        wait_idle("post_rst_idle");
        check_frames("post_rst", 8, 32'h0, 32'h0);

        // start while busy, and start coincident with frame_done, are both ignored
        clear_log();
        pulse_start();
        repeat (2) tick();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (frame_done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("ign_done_seen", {31'd0, found}, 1);
        pulse_start();
        repeat (10) tick();
        check("ign_busy", {31'd0, busy}, 0);
        check_frames("ign", 8, 32'h0, 32'h0);
        check("ign_done_count", fd_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ibniz_scan_seq.md
IBNIZ_SCAN_SEQ -- requirements
Module: ibniz_scan_seq

Interface
REQ-001 Parameter H_RES, default 256: pixels per line.
REQ-002 Parameter V_RES, default 192: lines per frame.
REQ-003 Parameter LAT, default 26: generator latency in enabled cycles, from T/X/Y presented to V valid.
REQ-004 Parameter XY_STEP, default 32'h0000_0200: signed 16.16 coordinate increment per pixel and per line.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 start  input  1  one-cycle request to render one frame.
REQ-008 cont  input  1  continuous mode; sampled at end of each frame.
REQ-009 t_step  input  32  signed value added to T after each completed frame.
REQ-010 gen_ena  output  1  generator advance enable.
REQ-011 T_out, X_out, Y_out  output  32 each  signed 16.16 operands to the generator.
REQ-012 V_in  input  32  generator result.
REQ-013 pix_valid  output  1  pixel write valid.
REQ-014 pix_ready  input  1  framebuffer accepts pixel.
REQ-015 pix_addr  output  clog2(H_RES*V_RES)  linear pixel address.
REQ-016 pix_data  output  32  pixel value.
REQ-017 busy  output  1  high in RUN or DRAIN.
REQ-018 frame_done  output  1  one-cycle pulse when the last pixel is accepted.

Function
REQ-019 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN when the last coordinate issues; DRAIN->RUN when tag pipe empties and cont=1, else DRAIN->IDLE.
REQ-020 Stall: adv = ~pix_valid | pix_ready; gen_ena = adv in every state.
REQ-021 In RUN with adv=1, one coordinate issues per cycle; a valid tag (1 bit + address) enters a LAT-deep shift register; in IDLE/DRAIN a zero tag enters.
REQ-022 Tag register shifts only when adv=1, giving exact alignment of tag and V_in.
REQ-023 Tag emerging with valid=1 loads pix_valid=1, pix_data=V_in, pix_addr=tag address; pix_valid drops on accept with no new tag.
REQ-024 X_out starts each line at -(H_RES/2)*XY_STEP and adds XY_STEP per issue; Y_out starts each frame at -(V_RES/2)*XY_STEP and adds XY_STEP at line wrap; X wraps to its origin on the same cycle.
REQ-025 Address increments by 1 per issue and wraps to 0 at frame start.
REQ-026 T_out is constant across a frame; T += t_step (32-bit wrap) on the frame_done cycle.
REQ-027 frame_done fires on acceptance of the pixel with address H_RES*V_RES-1.
REQ-028 start while busy is ignored; start and frame_done in the same cycle in IDLE-bound DRAIN: start is ignored.
REQ-029 Issue-to-pixel_valid latency is exactly LAT+1 cycles with pix_ready held high.

Reset
REQ-030 rst low: state IDLE, gen_ena 0, T/X/Y_out 0, tags cleared, pix_valid 0, pix_addr 0, pix_data 0, busy 0, frame_done 0.
REQ-031 Reset mid-frame discards all in-flight tags; no pixel write follows deassertion until a new start.
REQ-032 Reset deassertion is synchronised internally to clk before the FSM leaves IDLE.

Structure
REQ-033 Shared package ibniz_pkg holds the FSM state encoding, the 16.16 fixed-point width constant and the default XY_STEP.
REQ-034 The LAT-deep tag delay line is one sub-module, ibniz_tag_pipe (parameters DEPTH, WIDTH; input shift enable).

Verification
REQ-035 H_RES=4, V_RES=2, LAT=3, start with pix_ready=1 -> 8 writes, addresses 0..7, first pix_valid 4 cycles after first issue, frame_done once on addr 7.
REQ-036 Same config, X/Y trace -> X = -0x400,-0x200,0,0x200 per line; Y = -0x200 then 0.
REQ-037 pix_ready low 5 cycles mid-frame -> gen_ena low those cycles, pix_data/addr held, no address skipped or duplicated.
REQ-038 cont=1, t_step=0x10000 -> back-to-back frames, T_out 0x0 then 0x10000, no idle cycle between frames with pix_ready=1.
REQ-039 rst low at address 3 -> all outputs 0 within one cycle; after release, no write until start; next frame begins at addr 0.
REQ-040 start pulsed during RUN -> ignored; exactly 8 writes, one frame_done.
